// File: rtl/xlr8_fdiv_iter.sv
//============================================================================
// xlr8_fdiv_iter : iterative restoring floating-point divider, RNE, FTZ
// Revision 1.0
//============================================================================
`default_nettype none

module xlr8_fdiv_iter #(
  parameter  int EXP_W  = 8,
  parameter  int FRAC_W = 23,
  localparam int DW     = 1 + EXP_W + FRAC_W,
  localparam int MANT_W = FRAC_W + 1,
  localparam int N      = MANT_W + 2,
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clken,
  input  logic          start,
  input  logic [DW-1:0] numer,
  input  logic [DW-1:0] denom,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] q_out,
  output logic [3:0]    flags
);

  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [EW-1:0]        BIAS_E = EW'(BIAS);
  localparam logic [DW-1:0]        QNAN   = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, ROUND = 2'd2} state_t;

  state_t                  state;
  logic                    sign;
  logic signed [EW-1:0]    exp_r;
  logic [MANT_W:0]         rem;
  logic [MANT_W-1:0]       divisor;
  logic [N-1:0]            q;
  logic [CW-1:0]           cnt;
  logic                    special;
  logic [DW-1:0]           spec_q;
  logic [3:0]              spec_flags;

  logic [EXP_W-1:0]  en, ed;
  logic [FRAC_W-1:0] fn, fd;
  logic              in_sign;
  logic              n_zero, n_inf, n_nan, d_zero, d_inf, d_nan;

  assign en      = numer[DW-2:FRAC_W];
  assign ed      = denom[DW-2:FRAC_W];
  assign fn      = numer[FRAC_W-1:0];
  assign fd      = denom[FRAC_W-1:0];
  assign in_sign = numer[DW-1] ^ denom[DW-1];
  assign n_zero  = (en == '0);
  assign d_zero  = (ed == '0);
  assign n_inf   = (&en) & ~(|fn);
  assign d_inf   = (&ed) & ~(|fd);
  assign n_nan   = (&en) & (|fn);
  assign d_nan   = (&ed) & (|fd);

  logic          cap_special;
  logic [DW-1:0] cap_q;
  logic [3:0]    cap_flags;

  always_comb begin
    cap_special = 1'b1;
    cap_q       = '0;
    cap_flags   = '0;
    if (n_nan | d_nan | (n_zero & d_zero) | (n_inf & d_inf)) begin
      cap_q     = QNAN;
      cap_flags = 4'b1000;
    end else if (n_inf | d_zero) begin
      cap_q     = {in_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      cap_flags = {1'b0, d_zero & ~n_inf, 2'b00};
    end else if (n_zero | d_inf) begin
      cap_q     = {in_sign, {(DW-1){1'b0}}};
    end else begin
      cap_special = 1'b0;
    end
  end

  // Restoring step; the partial remainder is always below 2*divisor.
  logic                brw;
  logic [MANT_W-1:0]   diff;
  logic [MANT_W:0]     rem_nxt;

  assign brw     = (rem < {1'b0, divisor});
  assign diff    = rem[MANT_W-1:0] - divisor;
  assign rem_nxt = brw ? {rem[MANT_W-1:0], 1'b0} : {diff, 1'b0};

  logic [FRAC_W-1:0]    frac;
  logic [FRAC_W:0]      frac_inc;
  logic                 g, s;
  logic signed [EW-1:0] e_n;
  logic [DW-1:0]        res_q;
  logic [3:0]           res_flags;

  // The hidden bit is always 1 after normalisation, so a fraction carry means 2.0.
  always_comb begin
    frac = q[N-3:1];
    g    = q[0];
    s    = |rem;
    e_n  = exp_r - E_ONE;
    if (q[N-1]) begin
      frac = q[N-2:2];
      g    = q[1];
      s    = q[0] | (|rem);
      e_n  = exp_r;
    end
    frac_inc = {1'b0, frac} + {{FRAC_W{1'b0}}, g & (s | frac[0])};
    if (frac_inc[FRAC_W]) e_n = e_n + E_ONE;
    res_q     = {sign, e_n[EXP_W-1:0], frac_inc[FRAC_W-1:0]};
    res_flags = '0;
    if (e_n >= E_MAX) begin
      res_q     = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      res_flags = 4'b0010;
    end else if (e_n <= E_ZERO) begin
      res_q     = {sign, {(DW-1){1'b0}}};
      res_flags = 4'b0001;
    end
    if (special) begin
      res_q     = spec_q;
      res_flags = spec_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      q_out      <= '0;
      flags      <= '0;
      sign       <= 1'b0;
      exp_r      <= '0;
      rem        <= '0;
      divisor    <= '0;
      q          <= '0;
      cnt        <= '0;
      special    <= 1'b0;
      spec_q     <= '0;
      spec_flags <= '0;
    end else if (clken) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign       <= in_sign;
            exp_r      <= $signed({2'b00, en} - {2'b00, ed} + BIAS_E);
            rem        <= {2'b01, fn};
            divisor    <= {1'b1, fd};
            q          <= '0;
            cnt        <= CW'(N);
            special    <= cap_special;
            spec_q     <= cap_q;
            spec_flags <= cap_flags;
            busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          q   <= {q[N-2:0], ~brw};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ROUND;
        end
        ROUND: begin
          q_out <= res_q;
          flags <= res_flags;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
